// File: rtl/issue_sched.sv
// Issue scheduler: picks at most one ready RS entry for the ALU and one for the
// non-pipelined multiplier each cycle, and tracks multiplier occupancy.
// Optional feature macro: ISSUE_SCHED_RR_EN selects round-robin search from
// per-path pointers; when undefined, both paths use fixed lowest-index priority.
module issue_sched #(
  parameter int unsigned RS_SIZE  = 8,
  parameter int unsigned MULT_LAT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               squash,
  input  logic [RS_SIZE-1:0] ready_vec,
  input  logic [RS_SIZE-1:0] is_mult_vec,
  output logic [RS_SIZE-1:0] alu_grant,
  output logic               alu_grant_valid,
  output logic [RS_SIZE-1:0] mult_grant,
  output logic               mult_grant_valid,
  output logic               mult_busy
);

  localparam int unsigned PtrW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int unsigned CntW = $clog2(MULT_LAT + 1);

  // First set bit of cand at or above start, wrapping modulo RS_SIZE.
  function automatic logic [RS_SIZE-1:0] pick(input logic [RS_SIZE-1:0] cand,
                                              input logic [PtrW-1:0]    start);
    logic [RS_SIZE-1:0] g;
    logic               found;
    logic [PtrW-1:0]    idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RS_SIZE; k++) begin
      idx = PtrW'((32'(start) + k) % RS_SIZE);
      if (!found && cand[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  logic [RS_SIZE-1:0] alu_cand;
  logic [RS_SIZE-1:0] mult_cand;
  logic               block;
  logic [PtrW-1:0]    alu_start;
  logic [PtrW-1:0]    mult_start;
  logic [CntW-1:0]    mult_cnt_q, mult_cnt_d;

  assign alu_cand  = ready_vec & ~is_mult_vec;
  assign mult_cand = ready_vec & is_mult_vec;
  assign block     = stall | squash | reset;

`ifdef ISSUE_SCHED_RR_EN
  logic [PtrW-1:0] alu_ptr_q, alu_ptr_d;
  logic [PtrW-1:0] mult_ptr_q, mult_ptr_d;

  // Pointer just past the granted index; holds when nothing was granted.
  function automatic logic [PtrW-1:0] next_ptr(input logic [RS_SIZE-1:0] onehot,
                                               input logic [PtrW-1:0]    cur);
    logic [PtrW-1:0] r;
    r = cur;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (onehot[i]) r = PtrW'((i + 1) % RS_SIZE);
    end
    return r;
  endfunction

  assign alu_start  = alu_ptr_q;
  assign mult_start = mult_ptr_q;

  // Advance each round-robin pointer past its granted entry.
  always_comb begin
    alu_ptr_d  = next_ptr(alu_grant, alu_ptr_q);
    mult_ptr_d = next_ptr(mult_grant, mult_ptr_q);
  end

  // Pointer state; squash and stall leave it alone since grants are already gated.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_ptr_q  <= '0;
      mult_ptr_q <= '0;
    end else begin
      alu_ptr_q  <= alu_ptr_d;
      mult_ptr_q <= mult_ptr_d;
    end
  end
`else
  assign alu_start  = '0;
  assign mult_start = '0;
`endif

  // Grant selection; the multiplier is only offered when its occupancy has drained.
  always_comb begin
    alu_grant  = '0;
    mult_grant = '0;
    if (!block) begin
      alu_grant = pick(alu_cand, alu_start);
      if (mult_cnt_q == '0) mult_grant = pick(mult_cand, mult_start);
    end
  end

  assign alu_grant_valid  = |alu_grant;
  assign mult_grant_valid = |mult_grant;
  assign mult_busy        = (mult_cnt_q != '0) && !reset;

  // Occupancy counter keeps draining through stalls; squash drops the in-flight multiply.
  always_comb begin
    mult_cnt_d = mult_cnt_q;
    if (squash) begin
      mult_cnt_d = '0;
    end else if (mult_grant_valid) begin
      mult_cnt_d = CntW'(MULT_LAT - 1);
    end else if (mult_cnt_q != '0) begin
      mult_cnt_d = mult_cnt_q - CntW'(1);
    end
  end

  // Occupancy counter register.
  always_ff @(posedge clock) begin
    if (reset) mult_cnt_q <= '0;
    else       mult_cnt_q <= mult_cnt_d;
  end

endmodule

// File: tb/tb_issue_sched.sv
// Directed, table-driven bench for issue_sched (RS_SIZE=8, MULT_LAT=4).
// Expected values follow ISSUE_SCHED_RR_EN: round-robin when defined, else fixed priority.
module tb_issue_sched;

`ifdef ISSUE_SCHED_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, stall, squash;
  logic [7:0] ready_vec, is_mult_vec;
  logic [7:0] alu_grant, mult_grant;
  logic       alu_grant_valid, mult_grant_valid, mult_busy;

  int checks   = 0;
  int failures = 0;

  issue_sched #(
    .RS_SIZE  (8),
    .MULT_LAT (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .squash           (squash),
    .ready_vec        (ready_vec),
    .is_mult_vec      (is_mult_vec),
    .alu_grant        (alu_grant),
    .alu_grant_valid  (alu_grant_valid),
    .mult_grant       (mult_grant),
    .mult_grant_valid (mult_grant_valid),
    .mult_busy        (mult_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       stl;
    logic       sq;
    logic [7:0] rdy;
    logic [7:0] ism;
    logic [7:0] ea;
    logic [7:0] em;
    logic       eb;
  } vec_t;

  localparam int NVec = 29;
  vec_t tbl [NVec];

  function automatic vec_t v(input logic rst, input logic stl, input logic sq,
                             input logic [7:0] rdy, input logic [7:0] ism,
                             input logic [7:0] ea, input logic [7:0] em, input logic eb);
    vec_t r;
    r.rst = rst; r.stl = stl; r.sq = sq; r.rdy = rdy; r.ism = ism;
    r.ea = ea; r.em = em; r.eb = eb;
    return r;
  endfunction

  task automatic check(input string name, input int row, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%b expected=%b", name, row, got, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic [7:0] ea, input logic [7:0] em,
                               input logic eb);
    check("alu_grant", row, alu_grant, ea);
    check("alu_grant_valid", row, {7'd0, alu_grant_valid}, {7'd0, (ea != 8'd0)});
    check("mult_grant", row, mult_grant, em);
    check("mult_grant_valid", row, {7'd0, mult_grant_valid}, {7'd0, (em != 8'd0)});
    check("mult_busy", row, {7'd0, mult_busy}, {7'd0, eb});
  endtask

  initial begin
    int gap;
    bit seen;

    // rst stl sq  ready   is_mult  exp_alu           exp_mult          busy
    tbl[0]  = v(0, 0, 0, 8'h06, 8'h00, 8'h02,            8'h00,            0);
    tbl[1]  = v(0, 0, 0, 8'h06, 8'h00, Rr ? 8'h04 : 8'h02, 8'h00,          0);
    tbl[2]  = v(0, 0, 0, 8'h06, 8'h00, 8'h02,            8'h00,            0);
    tbl[3]  = v(0, 0, 0, 8'h81, 8'h01, 8'h80,            8'h01,            0);
    tbl[4]  = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[5]  = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[6]  = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[7]  = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            Rr ? 8'h10 : 8'h01, 0);
    tbl[8]  = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[9]  = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[10] = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[11] = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h01,            0);
    tbl[12] = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[13] = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[14] = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            8'h00,            1);
    tbl[15] = v(0, 0, 0, 8'h11, 8'h11, 8'h00,            Rr ? 8'h10 : 8'h01, 0);
    // stall right after a multiplier grant: counter still drains 3,2,1
    tbl[16] = v(0, 1, 0, 8'h13, 8'h11, 8'h00,            8'h00,            1);
    tbl[17] = v(0, 1, 0, 8'h13, 8'h11, 8'h00,            8'h00,            1);
    tbl[18] = v(0, 1, 0, 8'h13, 8'h11, 8'h00,            8'h00,            1);
    tbl[19] = v(0, 0, 0, 8'h13, 8'h11, 8'h02,            8'h01,            0);
    // squash the cycle after a multiplier grant
    tbl[20] = v(0, 0, 1, 8'h13, 8'h11, 8'h00,            8'h00,            1);
    tbl[21] = v(0, 0, 0, 8'h13, 8'h11, 8'h02,            Rr ? 8'h10 : 8'h01, 0);
    // reset mid-multiply
    tbl[22] = v(1, 0, 0, 8'h13, 8'h11, 8'h00,            8'h00,            0);
    tbl[23] = v(0, 0, 0, 8'h13, 8'h11, 8'h02,            8'h01,            0);
    // ALU wrap-around: pointer parked at 7, then only entry 0 ready
    tbl[24] = v(0, 0, 0, 8'h40, 8'h00, 8'h40,            8'h00,            1);
    tbl[25] = v(0, 0, 0, 8'h01, 8'h00, 8'h01,            8'h00,            1);
    tbl[26] = v(0, 0, 0, 8'h03, 8'h00, Rr ? 8'h02 : 8'h01, 8'h00,          1);
    tbl[27] = v(0, 0, 0, 8'h00, 8'h00, 8'h00,            8'h00,            0);
    tbl[28] = v(0, 0, 0, 8'h80, 8'h80, 8'h00,            8'h80,            0);

    reset = 1'b1; stall = 1'b0; squash = 1'b0;
    ready_vec = 8'hFF; is_mult_vec = 8'h0F;

    // While reset is high, nothing is granted and the multiplier reads idle.
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      check_outputs(-1 - c, 8'h00, 8'h00, 1'b0);
    end

    for (int i = 0; i < NVec; i++) begin
      @(negedge clock);
      reset       = tbl[i].rst;
      stall       = tbl[i].stl;
      squash      = tbl[i].sq;
      ready_vec   = tbl[i].rdy;
      is_mult_vec = tbl[i].ism;
      #1;
      check_outputs(i, tbl[i].ea, tbl[i].em, tbl[i].eb);
    end

    // Throughput: after the row-28 grant, the next grant arrives MULT_LAT cycles later.
    gap  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      reset = 1'b0; stall = 1'b0; squash = 1'b0;
      ready_vec = 8'h01; is_mult_vec = 8'h01;
      #1;
      if (mult_grant_valid) begin
        seen = 1'b1;
        check("post_grant", 100, mult_grant, 8'h01);
      end else begin
        gap++;
      end
    end
    check("mult_gap", 101, 8'(gap), 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
